// File: rtl/bin_to_res_deadlock_monitor_param_if.sv
// Signal bundle between the bin_to_res datapath and its deadlock monitor.
//   master : the datapath side. It drives the stall/idle/block indications
//            and the clear strobe, and observes the monitor status.
//   slave  : the monitor side. It consumes the indications and drives the
//            status outputs.
// Signals:
//   axis_block_sigs [N_AXIS]  1 = axis channel k stalled this cycle
//   inst_idle_sigs  [NI]      1 = sub-instance j idle
//   inst_block_sigs [NI]      1 = sub-instance j reports blocked
//   clear                     synchronous release of sticky/capture state
//   axis_block_info [2*N_AXIS] per-channel code (00 idle, 01 counting, 11 confirmed)
//   inst_block_info [NI]      1 = sub-instance j confirmed blocked
//   first_src       [6]       first confirmed source (axis k = k, inst j = 32+j)
//   block                     deadlock confirmed
//   event_count     [CNT_W]   saturating count of entries into BLOCKED
interface bin_to_res_deadlock_monitor_param_if #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 1,
  parameter int CNT_W  = 16
);
  localparam int NI = (N_INST > 0) ? N_INST : 1;

  logic [N_AXIS-1:0]   axis_block_sigs;
  logic [NI-1:0]       inst_idle_sigs;
  logic [NI-1:0]       inst_block_sigs;
  logic                clear;
  logic [2*N_AXIS-1:0] axis_block_info;
  logic [NI-1:0]       inst_block_info;
  logic [5:0]          first_src;
  logic                block;
  logic [CNT_W-1:0]    event_count;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  axis_block_info, inst_block_info, first_src, block, event_count
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output axis_block_info, inst_block_info, first_src, block, event_count
  );
endinterface

// File: rtl/bin_to_res_deadlock_monitor_param.sv
// Parametrised deadlock monitor for the bin_to_res datapath.
// Each source (N_AXIS stream channels, N_INST sub-instances) owns a
// persistence counter. A source is confirmed once it has been blocked for
// THRESH consecutive cycles, and any confirmed source moves the FSM to
// BLOCKED. With STICKY=1 the BLOCKED state and the confirmed fields hold
// until clear. Every output comes straight from a register.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high; zeroes all state including event_count
//   bus    slave side of bin_to_res_deadlock_monitor_param_if
module bin_to_res_deadlock_monitor_param #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 1,
  parameter int THRESH = 16,
  parameter int STICKY = 0,
  parameter int CNT_W  = 16
) (
  input  logic clock,
  input  logic reset,
  bin_to_res_deadlock_monitor_param_if.slave bus
);
  localparam int NI = (N_INST > 0) ? N_INST : 1;
  // Inst slots always exist in the source vector; tied to 0 when N_INST == 0.
  localparam int NS = N_AXIS + NI;
  localparam int TW = $clog2(THRESH + 1);
  localparam logic [TW-1:0] THR = TW'(THRESH);

  typedef enum logic [1:0] {IDLE, COUNTING, BLOCKED} state_t;

  state_t              state, state_nxt;
  logic [TW-1:0]       cnt     [NS];
  logic [TW-1:0]       cnt_nxt [NS];
  logic [NS-1:0]       raw, conf_nxt, busy_nxt;
  logic [NS-1:0]       latch, latch_nxt;
  logic                entry;
  logic [5:0]          first_src_r, first_src_nxt;
  logic                block_r;
  logic [2*N_AXIS-1:0] info_r, info_nxt;
  logic [NI-1:0]       inst_info_r, inst_info_nxt;
  logic [CNT_W-1:0]    event_count_r;
  logic                unused_inst;

  function automatic logic [TW-1:0] sat_inc_cnt(input logic [TW-1:0] v);
    sat_inc_cnt = (v == THR) ? THR : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_evt(input logic [CNT_W-1:0] v);
    sat_inc_evt = (&v) ? v : v + 1'b1;
  endfunction

  // Lowest-index confirmed source; axis slots come first, so axis wins ties.
  function automatic logic [5:0] first_of(input logic [NS-1:0] c);
    first_of = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (c[s]) first_of = (s < N_AXIS) ? 6'(s) : 6'(32 + s - N_AXIS);
    end
  endfunction

  assign unused_inst = ^{bus.inst_idle_sigs, bus.inst_block_sigs};

  always_comb begin
    raw = '0;
    for (int k = 0; k < N_AXIS; k++) raw[k] = bus.axis_block_sigs[k];
    if (N_INST > 0) begin
      for (int j = 0; j < NI; j++)
        raw[N_AXIS + j] = bus.inst_block_sigs[j] & ~bus.inst_idle_sigs[j];
    end
  end

  // Next-state counters: a low cycle or a clear restarts the count.
  always_comb begin
    conf_nxt = '0;
    busy_nxt = '0;
    for (int s = 0; s < NS; s++) begin
      cnt_nxt[s]  = (bus.clear || !raw[s]) ? '0 : sat_inc_cnt(cnt[s]);
      conf_nxt[s] = (cnt_nxt[s] == THR);
      busy_nxt[s] = (cnt_nxt[s] != '0);
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (|conf_nxt) state_nxt = BLOCKED;
                  else if (|raw) state_nxt = COUNTING;
        COUNTING: if (|conf_nxt) state_nxt = BLOCKED;
                  else if (!(|raw)) state_nxt = IDLE;
        BLOCKED:  if (STICKY == 0 && !(|conf_nxt)) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    entry     = (state != BLOCKED) && (state_nxt == BLOCKED);
    latch_nxt = '0;
    if (STICKY != 0 && !bus.clear) latch_nxt = latch | conf_nxt;

    if (state_nxt != BLOCKED) first_src_nxt = '0;
    else if (entry)           first_src_nxt = first_of(conf_nxt);
    else                      first_src_nxt = first_src_r;

    info_nxt = '0;
    for (int k = 0; k < N_AXIS; k++) begin
      if (latch_nxt[k] || conf_nxt[k]) info_nxt[2*k +: 2] = 2'b11;
      else if (busy_nxt[k])            info_nxt[2*k +: 2] = 2'b01;
    end
    if (STICKY == 0 && state_nxt != BLOCKED) info_nxt = '0;

    if (STICKY != 0)                inst_info_nxt = latch_nxt[NS-1:N_AXIS];
    else if (state_nxt == BLOCKED)  inst_info_nxt = conf_nxt[NS-1:N_AXIS];
    else                            inst_info_nxt = '0;
  end

  // Register stage: all monitor state and every output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      for (int s = 0; s < NS; s++) cnt[s] <= '0;
      latch         <= '0;
      first_src_r   <= '0;
      block_r       <= 1'b0;
      info_r        <= '0;
      inst_info_r   <= '0;
      event_count_r <= '0;
    end else begin
      state         <= state_nxt;
      for (int s = 0; s < NS; s++) cnt[s] <= cnt_nxt[s];
      latch         <= latch_nxt;
      first_src_r   <= first_src_nxt;
      block_r       <= (state_nxt == BLOCKED);
      info_r        <= info_nxt;
      inst_info_r   <= inst_info_nxt;
      if (entry) event_count_r <= sat_inc_evt(event_count_r);
    end
  end

  assign bus.axis_block_info = info_r;
  assign bus.inst_block_info = inst_info_r;
  assign bus.first_src       = first_src_r;
  assign bus.block           = block_r;
  assign bus.event_count     = event_count_r;
endmodule

// File: tb/tb_bin_to_res_deadlock_monitor_param.sv
// Bench for bin_to_res_deadlock_monitor_param. Four monitors with different
// parameter sets share the clock and reset:
//   0: THRESH=4 STICKY=0   1: THRESH=1 STICKY=0 (legacy)
//   2: THRESH=2 STICKY=1   3: THRESH=2 STICKY=0 CNT_W=2
// The reference model tracks the run length of every source and derives
// block/first_src/event_count from the confirmation rules.
module tb_bin_to_res_deadlock_monitor_param;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int TH   [4] = '{4, 1, 2, 2};
  int ST   [4] = '{0, 0, 1, 0};
  int CMAX [4] = '{65535, 65535, 65535, 3};

  bin_to_res_deadlock_monitor_param_if #(.N_AXIS(2), .N_INST(1), .CNT_W(16)) if0 ();
  bin_to_res_deadlock_monitor_param_if #(.N_AXIS(2), .N_INST(1), .CNT_W(16)) if1 ();
  bin_to_res_deadlock_monitor_param_if #(.N_AXIS(2), .N_INST(1), .CNT_W(16)) if2 ();
  bin_to_res_deadlock_monitor_param_if #(.N_AXIS(2), .N_INST(1), .CNT_W(2))  if3 ();

  bin_to_res_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .THRESH(4), .STICKY(0), .CNT_W(16))
    dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
  bin_to_res_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .THRESH(1), .STICKY(0), .CNT_W(16))
    dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
  bin_to_res_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .THRESH(2), .STICKY(1), .CNT_W(16))
    dut2 (.clock(clock), .reset(reset), .bus(if2.slave));
  bin_to_res_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .THRESH(2), .STICKY(0), .CNT_W(2))
    dut3 (.clock(clock), .reset(reset), .bus(if3.slave));

  logic [1:0] in_axis [4];
  logic       in_idle [4];
  logic       in_inst [4];
  logic       in_clr  [4];

  int run  [4][3];
  bit mlat [4][3];
  bit mblk [4];
  int mfs  [4];
  int mev  [4];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic zero_inputs();
    for (int i = 0; i < 4; i++) begin
      in_axis[i] = 2'b00; in_idle[i] = 1'b0; in_inst[i] = 1'b0; in_clr[i] = 1'b0;
    end
    in_idle[1] = 1'b1;
  endtask

  task automatic model_reset(input int id);
    for (int s = 0; s < 3; s++) begin run[id][s] = 0; mlat[id][s] = 0; end
    mblk[id] = 0; mfs[id] = 0; mev[id] = 0;
  endtask

  task automatic model_step(input int id);
    bit raw [3];
    bit any, prev;
    raw[0] = in_axis[id][0];
    raw[1] = in_axis[id][1];
    raw[2] = in_inst[id] & ~in_idle[id];
    if (in_clr[id]) begin
      for (int s = 0; s < 3; s++) begin run[id][s] = 0; mlat[id][s] = 0; end
      mblk[id] = 0; mfs[id] = 0;
      return;
    end
    any = 0;
    for (int s = 0; s < 3; s++) begin
      run[id][s] = raw[s] ? ((run[id][s] < 100000) ? run[id][s] + 1 : run[id][s]) : 0;
      if (run[id][s] >= TH[id]) any = 1;
    end
    prev = mblk[id];
    mblk[id] = (ST[id] != 0) ? (prev | any) : any;
    if (mblk[id] && !prev) begin
      if (run[id][0] >= TH[id])      mfs[id] = 0;
      else if (run[id][1] >= TH[id]) mfs[id] = 1;
      else                           mfs[id] = 32;
      mev[id] = (mev[id] < CMAX[id]) ? mev[id] + 1 : mev[id];
    end
    if (!mblk[id]) mfs[id] = 0;
    if (ST[id] != 0)
      for (int s = 0; s < 3; s++) if (run[id][s] >= TH[id]) mlat[id][s] = 1;
  endtask

  function automatic logic [1:0] exp_code(input int id, input int s);
    if (ST[id] != 0) return mlat[id][s] ? 2'b11 : ((run[id][s] > 0) ? 2'b01 : 2'b00);
    if (run[id][s] >= TH[id]) return 2'b11;
    return (run[id][s] > 0) ? 2'b01 : 2'b00;
  endfunction

  task automatic check_dut(input int id);
    logic [3:0] info; logic iinf; logic [5:0] fs; logic blk; logic [15:0] ev;
    logic einf;
    case (id)
      0: begin info = if0.axis_block_info; iinf = if0.inst_block_info[0]; fs = if0.first_src;
               blk = if0.block; ev = if0.event_count; end
      1: begin info = if1.axis_block_info; iinf = if1.inst_block_info[0]; fs = if1.first_src;
               blk = if1.block; ev = if1.event_count; end
      2: begin info = if2.axis_block_info; iinf = if2.inst_block_info[0]; fs = if2.first_src;
               blk = if2.block; ev = if2.event_count; end
      default: begin info = if3.axis_block_info; iinf = if3.inst_block_info[0]; fs = if3.first_src;
               blk = if3.block; ev = {14'd0, if3.event_count}; end
    endcase
    chk($sformatf("d%0d block", id), 32'(blk), 32'(mblk[id]));
    chk($sformatf("d%0d first_src", id), 32'(fs), 32'(mfs[id]));
    chk($sformatf("d%0d event_count", id), 32'(ev), 32'(mev[id]));
    if (ST[id] == 0 && !mblk[id]) begin
      chk($sformatf("d%0d info_confirmed_bits", id), 32'({info[3], info[1]}), 32'd0);
      chk($sformatf("d%0d inst_info", id), 32'(iinf), 32'd0);
    end else begin
      chk($sformatf("d%0d info", id), 32'(info), 32'({exp_code(id, 1), exp_code(id, 0)}));
      einf = (ST[id] != 0) ? mlat[id][2] : (mblk[id] && run[id][2] >= TH[id]);
      chk($sformatf("d%0d inst_info", id), 32'(iinf), 32'(einf));
    end
  endtask

  task automatic step(input logic rst_in);
    reset = rst_in;
    if0.axis_block_sigs = in_axis[0]; if0.inst_idle_sigs = in_idle[0];
    if0.inst_block_sigs = in_inst[0]; if0.clear = in_clr[0];
    if1.axis_block_sigs = in_axis[1]; if1.inst_idle_sigs = in_idle[1];
    if1.inst_block_sigs = in_inst[1]; if1.clear = in_clr[1];
    if2.axis_block_sigs = in_axis[2]; if2.inst_idle_sigs = in_idle[2];
    if2.inst_block_sigs = in_inst[2]; if2.clear = in_clr[2];
    if3.axis_block_sigs = in_axis[3]; if3.inst_idle_sigs = in_idle[3];
    if3.inst_block_sigs = in_inst[3]; if3.clear = in_clr[3];
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rst_in) model_reset(i);
      else        model_step(i);
    end
  endtask

  task automatic step_chk(input logic rst_in);
    step(rst_in);
    for (int i = 0; i < 4; i++) check_dut(i);
  endtask

  initial begin
    logic prev_raw;
    zero_inputs();
    step(1'b1);
    step_chk(1'b1);

    // Reset while channel 0 sits one cycle short of confirmation.
    step(1'b0);
    zero_inputs(); in_axis[0] = 2'b01;
    for (int i = 0; i < 3; i++) step_chk(1'b0);
    step_chk(1'b1);
    chk("rst_mid_count block", 32'(if0.block), 32'd0);
    chk("rst_mid_count events", 32'(if0.event_count), 32'd0);
    zero_inputs(); step_chk(1'b0);
    in_axis[0] = 2'b01;
    for (int i = 0; i < 3; i++) step_chk(1'b0);
    chk("rst_restart block", 32'(if0.block), 32'd0);
    zero_inputs(); step_chk(1'b0);

    // THRESH=4, channel 0 held for four cycles then released.
    in_axis[0] = 2'b01;
    for (int i = 0; i < 4; i++) step_chk(1'b0);
    chk("tp1 block", 32'(if0.block), 32'd1);
    chk("tp1 info0", 32'(if0.axis_block_info[1:0]), 32'd3);
    chk("tp1 first_src", 32'(if0.first_src), 32'd0);
    chk("tp1 events", 32'(if0.event_count), 32'd1);
    zero_inputs(); step_chk(1'b0);
    chk("tp1 release block", 32'(if0.block), 32'd0);
    chk("tp1 release info", 32'(if0.axis_block_info), 32'd0);

    // One-cycle gap on channel 1 restarts the count.
    for (int i = 0; i < 8; i++) begin
      in_axis[0] = (i == 3) ? 2'b00 : 2'b10;
      step_chk(1'b0);
      if (i < 7) chk("gap block low", 32'(if0.block), 32'd0);
    end
    chk("gap block", 32'(if0.block), 32'd1);
    chk("gap first_src", 32'(if0.first_src), 32'd1);
    zero_inputs(); step_chk(1'b0);

    // Legacy THRESH=1: block follows the inputs with exactly one cycle delay.
    for (int i = 0; i < 40; i++) begin
      in_axis[1] = 2'($urandom_range(0, 3));
      in_inst[1] = 1'($urandom_range(0, 1));
      prev_raw = |in_axis[1];
      step_chk(1'b0);
      chk("legacy block", 32'(if1.block), 32'(prev_raw));
      chk("legacy confirmed", 32'({if1.axis_block_info[3], if1.axis_block_info[1]}),
          32'({in_axis[1][1], in_axis[1][0]}));
    end
    zero_inputs(); step_chk(1'b0);

    // Sticky: inst 0 blocked for two cycles, then released, then cleared.
    in_inst[2] = 1'b1;
    step_chk(1'b0); step_chk(1'b0);
    in_inst[2] = 1'b0;
    for (int i = 0; i < 3; i++) step_chk(1'b0);
    chk("sticky block", 32'(if2.block), 32'd1);
    chk("sticky inst_info", 32'(if2.inst_block_info), 32'd1);
    chk("sticky first_src", 32'(if2.first_src), 32'd32);
    in_clr[2] = 1'b1; in_axis[2] = 2'b11;
    step_chk(1'b0);
    chk("clear block", 32'(if2.block), 32'd0);
    chk("clear info", 32'(if2.axis_block_info), 32'd0);
    chk("clear first_src", 32'(if2.first_src), 32'd0);
    chk("clear events", 32'(if2.event_count), 32'd1);
    zero_inputs(); step_chk(1'b0);

    // Simultaneous axis 1 / inst 0 confirmation, then counter saturation.
    in_axis[3] = 2'b10; in_inst[3] = 1'b1;
    step_chk(1'b0); step_chk(1'b0);
    chk("simul first_src", 32'(if3.first_src), 32'd1);
    for (int e = 0; e < 4; e++) begin
      zero_inputs(); step_chk(1'b0);
      in_axis[3] = 2'b01;
      step_chk(1'b0); step_chk(1'b0);
    end
    chk("saturated events", 32'(if3.event_count), 32'd3);
    zero_inputs(); step_chk(1'b0);

    // Randomized traffic on all monitors, with occasional clears.
    for (int i = 0; i < 150; i++) begin
      for (int d = 0; d < 4; d++) begin
        in_axis[d] = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
        in_inst[d] = 1'($urandom_range(0, 3) != 0);
        in_idle[d] = (d == 1) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        in_clr[d]  = 1'($urandom_range(0, 15) == 0);
      end
      step_chk(1'b0);
    end

    // Reset while blocked: everything returns to zero.
    step_chk(1'b1);
    zero_inputs(); step_chk(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
